idss_window_bank: RTL and testbench

Parametrised input-data shift bank feeding the convolution PE array. Holds NB_UNITS independent KERNEL_SIZE x KERNEL_SIZE activation windows. Loads one KERNEL_SIZE-tall input column per accepted beat, either into one unit selected by an internal round-robin pointer or broadcast into all units. Raises a per-unit window-valid handshake whenever a unit holds a complete window. Supersedes the fixed 4-unit, 3x3, externally-selected load-enable structure.

---
 rtl/idss_window_bank_if.sv | 42 ++++
 rtl/idss_window_bank.sv | 115 +++++++++++
 tb/tb_idss_window_bank.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idss_window_bank_if.sv
// -----------------------------------------------------------------------------
// idss_window_bank_if
// Purpose : bundles the column-load handshake, mode controls and per-unit window
//           handshake of idss_window_bank into one interface.
// Signals :
//   col_in    [K*W]      input column, row r at [r*W +: W]
//   col_valid / col_ready  column handshake (source -> bank)
//   bcast                 1 = broadcast column to every unit, 0 = round-robin
//   tile_mode             0 = sliding (stride 1), 1 = tiled (stride K)
//   clear                 synchronous flush of fill state and pointer
//   win_valid / win_ready [N] per-unit window handshake (bank -> consumer)
//   win_data  [N*K*K*W]   element (u,c,r) at ((u*K + c)*K + r)*W, c=0 oldest
// Modports: master = column source / window consumer side, slave = the bank.
// -----------------------------------------------------------------------------
interface idss_window_bank_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NB_UNITS      = 4
) ();
    localparam int COL_W = KERNEL_SIZE * IO_DATA_WIDTH;
    localparam int WIN_W = KERNEL_SIZE * COL_W;

    logic [COL_W-1:0]          col_in;
    logic                      col_valid;
    logic                      col_ready;
    logic                      bcast;
    logic                      tile_mode;
    logic                      clear;
    logic [NB_UNITS-1:0]       win_valid;
    logic [NB_UNITS-1:0]       win_ready;
    logic [NB_UNITS*WIN_W-1:0] win_data;

    modport master (
        output col_in, col_valid, bcast, tile_mode, clear, win_ready,
        input  col_ready, win_valid, win_data
    );

    modport slave (
        input  col_in, col_valid, bcast, tile_mode, clear, win_ready,
        output col_ready, win_valid, win_data
    );
endinterface

// File: rtl/idss_window_bank.sv
// -----------------------------------------------------------------------------
// idss_window_bank
// Purpose : input-data shift bank for the convolution PE array. Holds NB_UNITS
//           independent KERNEL_SIZE x KERNEL_SIZE activation windows, loaded one
//           column per accepted beat into the round-robin unit or into all units
//           (broadcast). Each unit flags a complete, unconsumed window.
// Ports   :
//   clk        clock
//   arst_n_in  asynchronous reset, active low
//   bus        idss_window_bank_if.slave (column in, window out handshakes)
// -----------------------------------------------------------------------------
module idss_window_bank #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NB_UNITS      = 4
) (
    input  logic              clk,
    input  logic              arst_n_in,
    idss_window_bank_if.slave bus
);
    localparam int COL_W  = KERNEL_SIZE * IO_DATA_WIDTH;
    localparam int WIN_W  = KERNEL_SIZE * COL_W;
    localparam int FILL_W = $clog2(KERNEL_SIZE + 1);
    localparam int PTR_W  = (NB_UNITS > 1) ? $clog2(NB_UNITS) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KERNEL_SIZE);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NB_UNITS - 1);

    logic [PTR_W-1:0]    r_ptr;
    logic [NB_UNITS-1:0] w_pend;
    logic [NB_UNITS-1:0] w_sel;
    logic [NB_UNITS-1:0] w_unit_ok;
    logic [NB_UNITS-1:0] w_write;
    logic [NB_UNITS-1:0] w_consume;
    logic                w_target_ok;
    logic                w_col_ready;
    logic                w_accept;

    // A unit can take a column if it has no pending window, or if that window
    // is being consumed on the same edge.
    assign w_unit_ok   = ~w_pend | bus.win_ready;
    assign w_target_ok = bus.bcast ? (&w_unit_ok) : (|(w_unit_ok & w_sel));
    assign w_col_ready = !bus.clear && w_target_ok;
    assign w_accept    = bus.col_valid && w_col_ready;

    assign bus.col_ready = w_col_ready;
    assign bus.win_valid = w_pend;

    // Round-robin pointer; it only advances on round-robin loads.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_ptr <= '0;
        end else if (bus.clear) begin
            r_ptr <= '0;
        end else if (w_accept && !bus.bcast) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    for (genvar gi = 0; gi < NB_UNITS; gi++) begin : g_unit
        logic [WIN_W-1:0]  r_win;
        logic [FILL_W-1:0] r_fill;
        logic              r_pend;
        logic [FILL_W-1:0] w_fill_inc;
        logic              w_arm;

        assign w_sel[gi]     = (r_ptr == PTR_W'(gi));
        assign w_write[gi]   = w_accept && (bus.bcast || w_sel[gi]);
        assign w_consume[gi] = r_pend && bus.win_ready[gi] && !bus.clear;
        assign w_pend[gi]    = r_pend;

        assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
        // A write arms the window when it completes the fill; in sliding mode a
        // write into an already-full unit also yields a fresh window.
        assign w_arm = (w_fill_inc == FILL_FULL) && (!bus.tile_mode || (r_fill != FILL_FULL));

        // Column shift: newest column enters at the top slice (c = K-1).
        always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
                r_win <= '0;
            end else if (w_write[gi]) begin
                r_win <= {bus.col_in, r_win[WIN_W-1:COL_W]};
            end
        end

        always_ff @(posedge clk or negedge arst_n_in) begin
            if (!arst_n_in) begin
                r_fill <= '0;
                r_pend <= 1'b0;
            end else if (bus.clear) begin
                r_fill <= '0;
                r_pend <= 1'b0;
            end else if (w_write[gi] && w_consume[gi]) begin
                if (bus.tile_mode) begin
                    // The written column starts the next tile.
                    r_fill <= FILL_W'(1);
                    r_pend <= 1'b0;
                end else begin
                    r_fill <= FILL_FULL;
                    r_pend <= 1'b1;
                end
            end else if (w_write[gi]) begin
                r_fill <= w_fill_inc;
                r_pend <= r_pend | w_arm;
            end else if (w_consume[gi]) begin
                r_pend <= 1'b0;
                if (bus.tile_mode) begin
                    r_fill <= '0;
                end
            end
        end

        assign bus.win_data[gi*WIN_W +: WIN_W] = r_win;
    end
endmodule

// File: tb/tb_idss_window_bank.sv
module tb_idss_window_bank;
    localparam int W     = 16;
    localparam int K     = 3;
    localparam int N     = 4;
    localparam int COL_W = K * W;
    localparam int WIN_W = K * K * W;

    logic clk    = 1'b0;
    logic arst_n = 1'b1;
    always #5 clk = ~clk;

    idss_window_bank_if #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_UNITS(N)) a_if ();
    idss_window_bank_if #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_UNITS(1)) t_if ();

    idss_window_bank #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_UNITS(N)) u_dut_a (
        .clk       (clk),
        .arst_n_in (arst_n),
        .bus       (a_if.slave)
    );

    idss_window_bank #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_UNITS(1)) u_dut_t (
        .clk       (clk),
        .arst_n_in (arst_n),
        .bus       (t_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               unit;
        logic [WIN_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Column with value v in row 0, v+256 in row 1, v+512 in row 2.
    function automatic logic [COL_W-1:0] mkcol(input int v);
        logic [COL_W-1:0] c;
        c = '0;
        for (int r = 0; r < K; r++) c[r*W +: W] = W'(v + 256 * r);
        return c;
    endfunction

    // Window with oldest column a (c=0) and newest column c (c=K-1).
    function automatic logic [WIN_W-1:0] mkwin(input int a, input int b, input int c);
        return {mkcol(c), mkcol(b), mkcol(a)};
    endfunction

    task automatic test_reset();
        a_if.col_in = '0; a_if.col_valid = 1'b0; a_if.bcast = 1'b0;
        a_if.tile_mode = 1'b0; a_if.clear = 1'b0; a_if.win_ready = '0;
        t_if.col_in = '0; t_if.col_valid = 1'b0; t_if.bcast = 1'b0;
        t_if.tile_mode = 1'b1; t_if.clear = 1'b0; t_if.win_ready = 1'b1;
        #2 arst_n = 1'b0;
        #20;
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        n_tests++;
        if (a_if.win_valid !== '0) begin n_fail++; $display("FAIL reset_win_valid: got %b expected 0", a_if.win_valid); end
        n_tests++;
        if (a_if.win_data !== '0) begin n_fail++; $display("FAIL reset_win_data: got %h expected 0", a_if.win_data); end
        n_tests++;
        if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL reset_col_ready: got %b expected 1", a_if.col_ready); end
        n_tests++;
        if (t_if.win_valid !== 1'b0 || t_if.col_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_tiled_dut: win_valid %b col_ready %b expected 0 1", t_if.win_valid, t_if.col_ready);
        end
        $display("[TB] reset released");
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev, exp_v, rise;
        exp_t e;
        prev = '0;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (i > 1) begin
                exp_v = (i - 1 > 8) ? N'((1 << (i - 9)) - 1) : '0;
                n_tests++;
                if (a_if.win_valid !== exp_v) begin
                    n_fail++; $display("FAIL rr_win_valid after col %0d: got %b expected %b", i - 1, a_if.win_valid, exp_v);
                end
                rise = a_if.win_valid & ~prev;
                for (int u = 0; u < N; u++) begin
                    if (rise[u]) begin
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++; $display("FAIL rr_scoreboard: unit %0d rose with no expected window", u);
                        end else begin
                            e = sb.pop_front();
                            if (e.unit != u || a_if.win_data[u*WIN_W +: WIN_W] !== e.data) begin
                                n_fail++;
                                $display("FAIL rr_window: unit %0d data %h expected unit %0d data %h",
                                         u, a_if.win_data[u*WIN_W +: WIN_W], e.unit, e.data);
                            end
                        end
                    end
                end
                prev = a_if.win_valid;
            end
            if (i <= 12) begin
                a_if.col_in = mkcol(i);
                a_if.col_valid = 1'b1;
                if (i >= 9) begin
                    e.unit = (i - 1) % N;
                    e.data = mkwin(i - 8, i - 4, i);
                    sb.push_back(e);
                end
                #1;
                n_tests++;
                if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL rr_col_ready col %0d: got %b expected 1", i, a_if.col_ready); end
                $display("[TB] rr col %0d driven", i);
            end else begin
                a_if.col_valid = 1'b0;
            end
        end
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rr_sb_left: got %0d entries expected 0", sb.size()); end
        sb.delete();
        n_tests++;
        if (a_if.win_data[0 +: W] !== 16'd1 || a_if.win_data[K*W +: W] !== 16'd5 || a_if.win_data[2*K*W +: W] !== 16'd9) begin
            n_fail++; $display("FAIL rr_unit0_row0: got %0d %0d %0d expected 1 5 9",
                               a_if.win_data[0 +: W], a_if.win_data[K*W +: W], a_if.win_data[2*K*W +: W]);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        a_if.col_in = mkcol(13);
        a_if.col_valid = 1'b1;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b0) begin n_fail++; $display("FAIL bp_blocked: col_ready %b expected 0", a_if.col_ready); end
        @(negedge clk);
        n_tests++;
        if (a_if.win_data[0 +: WIN_W] !== mkwin(1, 5, 9) || a_if.win_valid !== 4'b1111) begin
            n_fail++; $display("FAIL bp_no_accept: data %h valid %b expected %h 1111", a_if.win_data[0 +: WIN_W], a_if.win_valid, mkwin(1, 5, 9));
        end
        a_if.win_ready = 4'b0001;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL bp_released: col_ready %b expected 1", a_if.col_ready); end
        $display("[TB] bp col 13 driven with consume of unit 0");
        @(negedge clk);
        a_if.col_valid = 1'b0;
        a_if.win_ready = '0;
        n_tests++;
        if (a_if.win_valid !== 4'b1111) begin n_fail++; $display("FAIL bp_rearm: win_valid %b expected 1111", a_if.win_valid); end
        n_tests++;
        if (a_if.win_data[0 +: WIN_W] !== mkwin(5, 9, 13)) begin
            n_fail++; $display("FAIL bp_slide_data: got %h expected %h", a_if.win_data[0 +: WIN_W], mkwin(5, 9, 13));
        end
        // Pointer has moved on to unit 1: readiness now follows unit 1's consumer.
        a_if.win_ready = 4'b0010;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ptr_advance: col_ready %b expected 1", a_if.col_ready); end
        a_if.win_ready = 4'b0001;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ptr_not_zero: col_ready %b expected 0", a_if.col_ready); end
        a_if.win_ready = '0;
    endtask

    task automatic test_tiled();
        exp_t e;
        logic exp_v;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i > 1) begin
                exp_v = ((i - 1) % 3 == 0);
                n_tests++;
                if (t_if.win_valid !== exp_v) begin
                    n_fail++; $display("FAIL tiled_win_valid after col %0d: got %b expected %b", i - 1, t_if.win_valid, exp_v);
                end
                if (t_if.win_valid === 1'b1) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL tiled_scoreboard: window with no expected entry");
                    end else begin
                        e = sb.pop_front();
                        if (t_if.win_data !== e.data) begin
                            n_fail++; $display("FAIL tiled_window: got %h expected %h", t_if.win_data, e.data);
                        end
                    end
                end
            end
            if (i <= 6) begin
                t_if.col_in = mkcol(20 + i);
                t_if.col_valid = 1'b1;
                if (i % 3 == 0) begin
                    e.unit = 0;
                    e.data = mkwin(18 + i, 19 + i, 20 + i);
                    sb.push_back(e);
                end
                #1;
                n_tests++;
                if (t_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL tiled_col_ready col %0d: got %b expected 1", i, t_if.col_ready); end
                $display("[TB] tiled col %0d driven", 20 + i);
            end else begin
                t_if.col_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_tests++;
        if (t_if.win_valid !== 1'b0) begin n_fail++; $display("FAIL tiled_consumed: win_valid %b expected 0", t_if.win_valid); end
        sb.delete();
    endtask

    task automatic test_broadcast();
        exp_t e;
        logic [N-1:0] prev, rise;
        @(negedge clk);
        a_if.clear = 1'b1;
        a_if.col_in = mkcol(99);
        a_if.col_valid = 1'b1;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b0) begin n_fail++; $display("FAIL bc_clear_blocks: col_ready %b expected 0", a_if.col_ready); end
        @(negedge clk);
        a_if.clear = 1'b0;
        a_if.col_valid = 1'b0;
        a_if.bcast = 1'b1;
        n_tests++;
        if (a_if.win_valid !== '0) begin n_fail++; $display("FAIL bc_after_clear: win_valid %b expected 0", a_if.win_valid); end
        prev = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_if.col_in = mkcol(31 + i);
            a_if.col_valid = 1'b1;
            if (i == 2) begin
                for (int u = 0; u < N; u++) begin e.unit = u; e.data = mkwin(31, 32, 33); sb.push_back(e); end
            end
            #1;
            n_tests++;
            if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL bc_col_ready col %0d: got %b expected 1", 31 + i, a_if.col_ready); end
            $display("[TB] bcast col %0d driven", 31 + i);
        end
        @(negedge clk);
        a_if.col_valid = 1'b0;
        n_tests++;
        if (a_if.win_valid !== 4'b1111) begin n_fail++; $display("FAIL bc_all_valid: win_valid %b expected 1111", a_if.win_valid); end
        rise = a_if.win_valid & ~prev;
        for (int u = 0; u < N; u++) begin
            if (rise[u]) begin
                n_tests++;
                e = sb.pop_front();
                if (e.unit != u || a_if.win_data[u*WIN_W +: WIN_W] !== e.data) begin
                    n_fail++; $display("FAIL bc_window unit %0d: got %h expected %h", u, a_if.win_data[u*WIN_W +: WIN_W], e.data);
                end
            end
        end
        sb.delete();
        a_if.win_ready = 4'b0001;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b0) begin n_fail++; $display("FAIL bc_partial_ready: col_ready %b expected 0", a_if.col_ready); end
        a_if.win_ready = 4'b1111;
        a_if.col_in = mkcol(34);
        a_if.col_valid = 1'b1;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL bc_full_ready: col_ready %b expected 1", a_if.col_ready); end
        $display("[TB] bcast col 34 driven with consume of all units");
        @(negedge clk);
        a_if.col_valid = 1'b0;
        a_if.win_ready = '0;
        n_tests++;
        if (a_if.win_valid !== 4'b1111 || a_if.win_data[3*WIN_W +: WIN_W] !== mkwin(32, 33, 34)) begin
            n_fail++; $display("FAIL bc_slide: valid %b unit3 %h expected 1111 %h", a_if.win_valid, a_if.win_data[3*WIN_W +: WIN_W], mkwin(32, 33, 34));
        end
        a_if.clear = 1'b1;
        @(negedge clk);
        a_if.clear = 1'b0;
        a_if.bcast = 1'b0;
    endtask

    task automatic test_clear_reset();
        exp_t e;
        logic [N-1:0] prev, exp_v, rise;
        for (int i = 41; i <= 42; i++) begin
            @(negedge clk);
            a_if.col_in = mkcol(i);
            a_if.col_valid = 1'b1;
            #1;
            n_tests++;
            if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL clr_col_ready col %0d: got %b expected 1", i, a_if.col_ready); end
            $display("[TB] clr col %0d driven", i);
        end
        @(negedge clk);
        a_if.col_in = mkcol(43);
        a_if.clear = 1'b1;
        #1;
        n_tests++;
        if (a_if.col_ready !== 1'b0) begin n_fail++; $display("FAIL clr_drop_ready: col_ready %b expected 0", a_if.col_ready); end
        @(negedge clk);
        a_if.clear = 1'b0;
        a_if.col_valid = 1'b0;
        n_tests++;
        if (a_if.win_valid !== '0 || a_if.win_data[(2*K*K + 2*K)*W +: W] !== 16'd34) begin
            n_fail++; $display("FAIL clr_dropped: valid %b unit2 newest %0d expected 0 34",
                               a_if.win_valid, a_if.win_data[(2*K*K + 2*K)*W +: W]);
        end
        prev = '0;
        for (int i = 44; i <= 53; i++) begin
            @(negedge clk);
            if (i > 44) begin
                exp_v = (i - 1 == 52) ? 4'b0001 : 4'b0000;
                n_tests++;
                if (a_if.win_valid !== exp_v) begin
                    n_fail++; $display("FAIL clr_win_valid after col %0d: got %b expected %b", i - 1, a_if.win_valid, exp_v);
                end
                if (i - 1 == 44) begin
                    n_tests++;
                    if (a_if.win_data[0 +: WIN_W] !== mkwin(34, 41, 44)) begin
                        n_fail++; $display("FAIL clr_first_unit0: got %h expected %h", a_if.win_data[0 +: WIN_W], mkwin(34, 41, 44));
                    end
                end
                rise = a_if.win_valid & ~prev;
                for (int u = 0; u < N; u++) begin
                    if (rise[u]) begin
                        n_tests++;
                        if (sb.size() == 0) begin
                            n_fail++; $display("FAIL clr_scoreboard: unit %0d rose with no expected window", u);
                        end else begin
                            e = sb.pop_front();
                            if (e.unit != u || a_if.win_data[u*WIN_W +: WIN_W] !== e.data) begin
                                n_fail++; $display("FAIL clr_window: unit %0d data %h expected unit %0d data %h",
                                                   u, a_if.win_data[u*WIN_W +: WIN_W], e.unit, e.data);
                            end
                        end
                    end
                end
                prev = a_if.win_valid;
            end
            if (i <= 52) begin
                a_if.col_in = mkcol(i);
                a_if.col_valid = 1'b1;
                if (i == 52) begin e.unit = 0; e.data = mkwin(44, 48, 52); sb.push_back(e); end
                #1;
                n_tests++;
                if (a_if.col_ready !== 1'b1) begin n_fail++; $display("FAIL clr_col_ready col %0d: got %b expected 1", i, a_if.col_ready); end
                $display("[TB] clr col %0d driven", i);
            end else begin
                a_if.col_valid = 1'b0;
            end
        end
        // Asynchronous reset in the low phase of the clock, mid-stream.
        a_if.col_in = mkcol(60);
        a_if.col_valid = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        n_tests++;
        if (a_if.win_valid !== '0) begin n_fail++; $display("FAIL arst_win_valid: got %b expected 0", a_if.win_valid); end
        n_tests++;
        if (a_if.win_data !== '0) begin n_fail++; $display("FAIL arst_win_data: got %h expected 0", a_if.win_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_if.col_valid = 1'b0;
        arst_n = 1'b1;
        #1;
        n_tests++;
        if (a_if.win_data !== '0 || a_if.col_ready !== 1'b1) begin
            n_fail++; $display("FAIL arst_release: data %h col_ready %b expected 0 1", a_if.win_data, a_if.col_ready);
        end
        $display("[TB] async reset pulse done");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_tiled();
        test_broadcast();
        test_clear_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
